pipe_controller: RTL and testbench

Pipelined successor to the single-cycle MIPS control decoder. Decodes the ID-stage instruction into a control word and carries that word through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards and inserts bubbles. Handles branch flush and global memory-wait freeze, and keeps a saturating stall counter. Sits beside the 5-stage datapath and replaces per-stage combinational control.

---
 rtl/pipe_ctrl_pkg.sv | 91 +++++++++
 rtl/pipe_controller_decode.sv | 145 ++++++++++++++
 rtl/pipe_controller.sv | 120 ++++++++++++
 tb/tb_pipe_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and control-word types for the pipelined MIPS controller.
// Opcodes, functs, ALU codes and per-stage control bundles.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_SYSC = 6'b001100;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // ALU-B / shift source: rt, immediate, shamt, rs-variable
  localparam logic [1:0] Y_REG   = 2'b00;
  localparam logic [1:0] Y_IMM   = 2'b01;
  localparam logic [1:0] Y_SHAMT = 2'b10;
  localparam logic [1:0] Y_SHV   = 2'b11;

  localparam logic [1:0] RW_RD  = 2'b00;
  localparam logic [1:0] RW_R31 = 2'b01;
  localparam logic [1:0] RW_RT  = 2'b11;

  localparam logic [1:0] W_ALU = 2'b00;
  localparam logic [1:0] W_PC4 = 2'b01;
  localparam logic [1:0] W_RAM = 2'b11;

  typedef struct packed {
    logic [3:0] alu_s;
    logic [1:0] y;
    logic       blez;
    logic       beq;
    logic       bne;
    logic       jr;
  } ex_ctrl_t;

  typedef struct packed {
    logic sto;
    logic load;
    logic half;
  } mem_ctrl_t;

  typedef struct packed {
    logic       we;
    logic [1:0] rw;
    logic [1:0] w;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_controller_decode.sv
// ID-stage instruction decoder: instruction word to control word.
// Purely combinational; also flags rt-readers and jumps.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        reads_rt,
  output logic        jump
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] dest;
  logic       unused_bits;

  assign op = instr[31:26];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign fn = instr[5:0];
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  // decode opcode/funct, then drop writes to $0
  always_comb begin
    ctrl     = CTRL_NOP;
    reads_rt = 1'b0;
    jump     = 1'b0;
    dest     = 5'd0;
    unique case (1'b1)
      (op == OP_R): begin
        reads_rt    = 1'b1;
        dest        = rd;
        ctrl.wb.we  = 1'b1;
        unique case (1'b1)
          (fn == F_ADD),
          (fn == F_ADDU): ctrl.ex.alu_s = ALU_ADD;
          (fn == F_SUB):  ctrl.ex.alu_s = ALU_SUB;
          (fn == F_AND):  ctrl.ex.alu_s = ALU_AND;
          (fn == F_OR):   ctrl.ex.alu_s = ALU_OR;
          (fn == F_NOR):  ctrl.ex.alu_s = ALU_NOR;
          (fn == F_SLT):  ctrl.ex.alu_s = ALU_SLT;
          (fn == F_SLTU): ctrl.ex.alu_s = ALU_SLTU;
          (fn == F_SLL): begin
            ctrl.ex.alu_s = ALU_SLL;
            ctrl.ex.y     = Y_SHAMT;
          end
          (fn == F_SRL): begin
            ctrl.ex.alu_s = ALU_SRL;
            ctrl.ex.y     = Y_SHAMT;
          end
          (fn == F_SRA): begin
            ctrl.ex.alu_s = ALU_SRA;
            ctrl.ex.y     = Y_SHAMT;
          end
          (fn == F_SRLV): begin
            ctrl.ex.alu_s = ALU_SRL;
            ctrl.ex.y     = Y_SHV;
          end
          (fn == F_SRAV): begin
            ctrl.ex.alu_s = ALU_SRA;
            ctrl.ex.y     = Y_SHV;
          end
          (fn == F_JR): begin
            ctrl.wb.we = 1'b0;
            ctrl.ex.jr = 1'b1;
          end
          default: ctrl = CTRL_NOP;
        endcase
      end
      (op == OP_ADDI),
      (op == OP_ADDIU): begin
        dest          = rt;
        ctrl.ex.alu_s = ALU_ADD;
        ctrl.ex.y     = Y_IMM;
        ctrl.wb.we    = 1'b1;
        ctrl.wb.rw    = RW_RT;
      end
      (op == OP_ANDI): begin
        dest          = rt;
        ctrl.ex.alu_s = ALU_AND;
        ctrl.ex.y     = Y_IMM;
        ctrl.wb.we    = 1'b1;
        ctrl.wb.rw    = RW_RT;
      end
      (op == OP_ORI): begin
        dest          = rt;
        ctrl.ex.alu_s = ALU_OR;
        ctrl.ex.y     = Y_IMM;
        ctrl.wb.we    = 1'b1;
        ctrl.wb.rw    = RW_RT;
      end
      (op == OP_SLTI): begin
        dest          = rt;
        ctrl.ex.alu_s = ALU_SLT;
        ctrl.ex.y     = Y_IMM;
        ctrl.wb.we    = 1'b1;
        ctrl.wb.rw    = RW_RT;
      end
      (op == OP_LH),
      (op == OP_LW): begin
        dest          = rt;
        ctrl.ex.y     = Y_IMM;
        ctrl.mem.load = 1'b1;
        ctrl.mem.half = (op == OP_LH);
        ctrl.wb.we    = 1'b1;
        ctrl.wb.rw    = RW_RT;
        ctrl.wb.w     = W_RAM;
      end
      (op == OP_SW),
      (op == OP_SH): begin
        reads_rt      = 1'b1;
        ctrl.ex.y     = Y_IMM;
        ctrl.mem.sto  = 1'b1;
        ctrl.mem.half = (op == OP_SH);
      end
      (op == OP_J): jump = 1'b1;
      (op == OP_JAL): begin
        jump       = 1'b1;
        dest       = 5'd31;
        ctrl.wb.we = 1'b1;
        ctrl.wb.rw = RW_R31;
        ctrl.wb.w  = W_PC4;
      end
      (op == OP_BEQ): begin
        reads_rt      = 1'b1;
        ctrl.ex.alu_s = ALU_SUB;
        ctrl.ex.beq   = 1'b1;
      end
      (op == OP_BNE): begin
        reads_rt      = 1'b1;
        ctrl.ex.alu_s = ALU_SUB;
        ctrl.ex.bne   = 1'b1;
      end
      (op == OP_BLEZ): begin
        ctrl.ex.alu_s = ALU_SUB;
        ctrl.ex.blez  = 1'b1;
      end
      default: ctrl = CTRL_NOP;
    endcase
    if (dest == 5'd0) ctrl.wb.we = 1'b0;
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control: ID decode carried through ID/EX, EX/MEM, MEM/WB.
// Load-use bubbles, branch flush, memory-wait freeze, stall counter.
module pipe_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int ALU_SEL_W  = 4,
  parameter int REG_ADDR_W = 5,
  parameter int HAZARD_EN  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           id_instr,
  input  logic                  id_valid,
  input  logic                  flush,
  input  logic                  mem_wait,
  output logic                  hazard_stall,
  output logic                  id_jump,
  output logic [ALU_SEL_W-1:0]  ex_alu_s,
  output logic [1:0]            ex_y,
  output logic                  ex_blez,
  output logic                  ex_beq,
  output logic                  ex_bne,
  output logic                  ex_jr,
  output logic                  mem_sto,
  output logic                  mem_load,
  output logic                  mem_half,
  output logic                  wb_we,
  output logic [1:0]            wb_rw,
  output logic [1:0]            wb_w,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [CNT_W-1:0]      stall_cnt
);

  ctrl_t                 id_c;
  logic                  id_reads_rt;
  logic                  id_jmp;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;

  logic                  ex_v;
  ctrl_t                 ex_q;
  logic [REG_ADDR_W-1:0] ex_rt_q;
  logic                  mem_v;
  mem_ctrl_t             mem_q;
  wb_ctrl_t              mem_wb_q;
  logic                  wb_v;
  wb_ctrl_t              wb_q;
  logic [CNT_W-1:0]      cnt_q;

  logic load_use;
  logic bubble;

  ctrl_decode u_dec (
    .instr    (id_instr),
    .ctrl     (id_c),
    .reads_rt (id_reads_rt),
    .jump     (id_jmp)
  );

  assign id_rs = REG_ADDR_W'(id_instr[25:21]);
  assign id_rt = REG_ADDR_W'(id_instr[20:16]);

  // load in EX whose rt feeds the ID instruction
  always_comb begin
    load_use = 1'b0;
    if (HAZARD_EN != 0 && ex_v && ex_q.mem.load &&
        ex_rt_q != '0) begin
      load_use = (ex_rt_q == id_rs) ||
                 (id_reads_rt && ex_rt_q == id_rt);
    end
  end

  assign bubble       = flush | load_use;
  assign hazard_stall = mem_wait | (load_use & ~flush);
  assign id_jump      = id_jmp & id_valid;

  // stage registers and saturating bubble counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v     <= 1'b0;
      ex_q     <= CTRL_NOP;
      ex_rt_q  <= '0;
      mem_v    <= 1'b0;
      mem_q    <= '0;
      mem_wb_q <= '0;
      wb_v     <= 1'b0;
      wb_q     <= '0;
      cnt_q    <= '0;
    end else if (!mem_wait) begin
      ex_v     <= id_valid & ~bubble;
      ex_q     <= id_c;
      ex_rt_q  <= id_rt;
      mem_v    <= ex_v;
      mem_q    <= ex_q.mem;
      mem_wb_q <= ex_q.wb;
      wb_v     <= mem_v;
      wb_q     <= mem_wb_q;
      if (bubble && cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign ex_alu_s = ALU_SEL_W'(ex_q.ex.alu_s) & {ALU_SEL_W{ex_v}};
  assign ex_y     = ex_q.ex.y & {2{ex_v}};
  assign ex_blez  = ex_q.ex.blez & ex_v;
  assign ex_beq   = ex_q.ex.beq & ex_v;
  assign ex_bne   = ex_q.ex.bne & ex_v;
  assign ex_jr    = ex_q.ex.jr & ex_v;
  assign ex_rt    = ex_rt_q & {REG_ADDR_W{ex_v}};
  assign mem_sto  = mem_q.sto & mem_v;
  assign mem_load = mem_q.load & mem_v;
  assign mem_half = mem_q.half & mem_v;
  assign wb_we    = wb_q.we & wb_v;
  assign wb_rw    = wb_q.rw & {2{wb_v}};
  assign wb_w     = wb_q.w & {2{wb_v}};
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller with a 2-bit stall counter.
// Hand-computed expectations checked a cycle at a time.
module tb_pipe_controller;

  logic        clk;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        flush;
  logic        mem_wait;
  logic        hazard_stall;
  logic        id_jump;
  logic [3:0]  ex_alu_s;
  logic [1:0]  ex_y;
  logic        ex_blez;
  logic        ex_beq;
  logic        ex_bne;
  logic        ex_jr;
  logic        mem_sto;
  logic        mem_load;
  logic        mem_half;
  logic        wb_we;
  logic [1:0]  wb_rw;
  logic [1:0]  wb_w;
  logic [4:0]  ex_rt;
  logic [1:0]  stall_cnt;

  int n_run;
  int n_fail;

  localparam logic [31:0] I_ADD   = 32'h00221820;
  localparam logic [31:0] I_SUB   = 32'h00221822;
  localparam logic [31:0] I_ORI   = 32'h34270005;
  localparam logic [31:0] I_SLL   = 32'h00021900;
  localparam logic [31:0] I_SLT   = 32'h0022182A;
  localparam logic [31:0] I_BAD   = 32'hFC000000;
  localparam logic [31:0] I_LW2   = 32'h8C220000;
  localparam logic [31:0] I_USE2  = 32'h00441820;
  localparam logic [31:0] I_LW0   = 32'h8C200000;
  localparam logic [31:0] I_USE0  = 32'h00041820;
  localparam logic [31:0] I_LW5   = 32'h8C250000;
  localparam logic [31:0] I_USE5  = 32'h00A53020;
  localparam logic [31:0] I_LW7   = 32'h8C270000;
  localparam logic [31:0] I_SW7   = 32'hAC270000;
  localparam logic [31:0] I_BEQ   = 32'h10220000;
  localparam logic [31:0] I_JAL   = 32'h0C000000;
  localparam logic [31:0] I_JR    = 32'h03E00008;

  pipe_controller #(.CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .flush        (flush),
    .mem_wait     (mem_wait),
    .hazard_stall (hazard_stall),
    .id_jump      (id_jump),
    .ex_alu_s     (ex_alu_s),
    .ex_y         (ex_y),
    .ex_blez      (ex_blez),
    .ex_beq       (ex_beq),
    .ex_bne       (ex_bne),
    .ex_jr        (ex_jr),
    .mem_sto      (mem_sto),
    .mem_load     (mem_load),
    .mem_half     (mem_half),
    .wb_we        (wb_we),
    .wb_rw        (wb_rw),
    .wb_w         (wb_w),
    .ex_rt        (ex_rt),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    id_valid = 1'b0;
    id_instr = '0;
    flush    = 1'b0;
    mem_wait = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] all_out();
    return 32'({ex_alu_s, ex_y, ex_blez, ex_beq, ex_bne, ex_jr,
                mem_sto, mem_load, mem_half, wb_we, wb_rw, wb_w,
                ex_rt, stall_cnt});
  endfunction

  logic [31:0] v_ins [6];
  logic [3:0]  v_alu [6];
  logic [1:0]  v_y   [6];

  initial begin
    n_run  = 0;
    n_fail = 0;
    v_ins = '{I_ADD, I_SUB, I_ORI, I_SLL, I_SLT, I_BAD};
    v_alu = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd5, 4'd0};
    v_y   = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};

    do_reset();
    chk("reset_outs", all_out(), 32'd0);
    chk("reset_stall", 32'(hazard_stall), 32'd0);

    // ALU stream, one instruction per cycle
    id_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      id_instr = v_ins[i];
      tick();
      chk($sformatf("alu_%0d", i), 32'(ex_alu_s), 32'(v_alu[i]));
      chk($sformatf("y_%0d", i), 32'(ex_y), 32'(v_y[i]));
      if (i == 2) begin
        chk("add_wb_we", 32'(wb_we), 32'd1);
        chk("add_wb_rw", 32'(wb_rw), 32'd0);
        chk("add_wb_w", 32'(wb_w), 32'd0);
      end
      if (i == 4) begin
        chk("ori_wb_we", 32'(wb_we), 32'd1);
        chk("ori_wb_rw", 32'(wb_rw), 32'd3);
      end
    end
    id_valid = 1'b0;
    tick();
    chk("slt_wb_we", 32'(wb_we), 32'd1);
    chk("ex_idle", 32'(ex_alu_s), 32'd0);
    tick();
    chk("bad_wb_we", 32'(wb_we), 32'd0);
    tick();
    chk("drain_outs", all_out(), 32'd0);

    // jal / jr
    id_valid = 1'b1;
    id_instr = I_JAL;
    #1;
    chk("jal_id_jump", 32'(id_jump), 32'd1);
    tick();
    id_instr = I_JR;
    #1;
    chk("jr_id_jump", 32'(id_jump), 32'd0);
    tick();
    chk("jr_ex_jr", 32'(ex_jr), 32'd1);
    id_valid = 1'b0;
    tick();
    chk("jal_wb", 32'({wb_we, wb_rw, wb_w}), 32'b1_01_01);

    // load-use on rs
    do_reset();
    id_valid = 1'b1;
    id_instr = I_LW2;
    #1;
    chk("lu_pre_stall", 32'(hazard_stall), 32'd0);
    tick();
    id_instr = I_USE2;
    #1;
    chk("lu_stall", 32'(hazard_stall), 32'd1);
    tick();
    chk("lu_bubble_ex", 32'({ex_alu_s, ex_rt}), 32'd0);
    chk("lu_mem_load", 32'(mem_load), 32'd1);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_stall_off", 32'(hazard_stall), 32'd0);
    tick();
    chk("lu_add_ex_rt", 32'(ex_rt), 32'd4);
    chk("lw_wb", 32'({wb_we, wb_rw, wb_w}), 32'b1_11_11);
    id_valid = 1'b0;
    tick();
    chk("bubble_wb_we", 32'(wb_we), 32'd0);
    tick();
    chk("add_late_wb", 32'({wb_we, wb_rw, wb_w}), 32'b1_00_00);

    // load to $0 never stalls or writes
    id_valid = 1'b1;
    id_instr = I_LW0;
    tick();
    id_instr = I_USE0;
    #1;
    chk("lw0_stall", 32'(hazard_stall), 32'd0);
    tick();
    id_valid = 1'b0;
    chk("lw0_cnt", 32'(stall_cnt), 32'd1);
    tick();
    chk("lw0_wb_we", 32'(wb_we), 32'd0);
    tick();
    chk("use0_wb_we", 32'(wb_we), 32'd1);

    // rt only counts when the ID instruction reads it
    id_valid = 1'b1;
    id_instr = I_LW7;
    tick();
    id_instr = I_ORI;
    #1;
    chk("ori_rt_nostall", 32'(hazard_stall), 32'd0);
    id_instr = I_SW7;
    #1;
    chk("sw_rt_stall", 32'(hazard_stall), 32'd1);
    id_instr = '0;
    id_valid = 1'b0;
    tick();

    // branch flush
    id_valid = 1'b1;
    id_instr = I_BEQ;
    tick();
    chk("beq_ex", 32'({ex_beq, ex_alu_s}), 32'b1_0001);
    id_instr = I_ORI;
    flush    = 1'b1;
    #1;
    chk("flush_stall", 32'(hazard_stall), 32'd0);
    tick();
    chk("flush_ex", 32'({ex_alu_s, ex_y, ex_beq, ex_rt}), 32'd0);
    chk("flush_cnt", 32'(stall_cnt), 32'd2);
    flush    = 1'b0;
    id_instr = I_LW5;
    tick();
    id_instr = I_USE5;
    flush    = 1'b1;
    #1;
    chk("flush_over_hz", 32'(hazard_stall), 32'd0);
    tick();
    chk("flush_hz_cnt", 32'(stall_cnt), 32'd3);
    chk("flush_hz_ex", 32'(ex_rt), 32'd0);
    flush    = 1'b0;
    id_valid = 1'b0;

    // memory wait freeze
    do_reset();
    id_valid = 1'b1;
    id_instr = I_ORI;
    tick();
    id_instr = I_SUB;
    tick();
    id_instr = I_SLT;
    mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_stall_%0d", i), 32'(hazard_stall), 32'd1);
      tick();
      chk($sformatf("mw_frozen_%0d", i),
          32'({ex_alu_s, ex_rt, wb_we, stall_cnt}),
          32'({4'd1, 5'd2, 1'b0, 2'd0}));
    end
    mem_wait = 1'b0;
    #1;
    chk("mw_release", 32'(hazard_stall), 32'd0);
    tick();
    id_valid = 1'b0;
    chk("mw_resume_ex", 32'(ex_alu_s), 32'd5);
    chk("mw_resume_wb", 32'({wb_we, wb_rw}), 32'b1_11);
    tick();
    chk("mw_sub_wb", 32'({wb_we, wb_rw}), 32'b1_00);

    // counter saturation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      id_valid = 1'b1;
      id_instr = I_LW5;
      tick();
      id_instr = I_USE5;
      tick();
      chk($sformatf("sat_%0d", i), 32'(stall_cnt),
          (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end

    // reset in the middle of a stall
    id_instr = I_LW5;
    tick();
    id_instr = I_USE5;
    #1;
    chk("rst_pre_stall", 32'(hazard_stall), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_outs", all_out(), 32'd0);
    chk("rst_mid_stall", 32'(hazard_stall), 32'd0);
    rst      = 1'b0;
    id_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
